// File: rtl/lms_pkg.sv
// Shared constants, FSM state type and saturation helper for the LMS error stage.
package lms_pkg;

   localparam int TAPS    = 16;
   localparam int XW      = 14;
   localparam int WW      = 32;
   localparam int EW      = 32;
   localparam int Y_SHIFT = 16;
   localparam int ACCW    = 50;
   localparam int KW      = $clog2(TAPS);

   typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} state_t;

   // In range when every bit above the EW-bit sign bit matches it.
   function automatic logic [EW-1:0] sat32(input logic signed [ACCW-1:0] v);
      if (v[ACCW-1:EW-1] == '0 || v[ACCW-1:EW-1] == '1)
         return v[EW-1:0];
      else if (v[ACCW-1])
         return {1'b1, {(EW-1){1'b0}}};
      else
         return {1'b0, {(EW-1){1'b1}}};
   endfunction

endpackage

// File: rtl/lms_tap_line.sv
// Reference-sample delay line: shifts in a new sample on accept, exposes all taps
// plus an indexed read port for the sequential MAC.
module lms_tap_line
   import lms_pkg::*;
(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     shift_en,
   input  logic [XW-1:0]            din,
   input  logic [KW-1:0]            rd_idx,
   output logic [TAPS-1:0][XW-1:0]  taps,
   output logic [XW-1:0]            rd_data
);

   logic [TAPS-1:0][XW-1:0] taps_q, taps_d;

   // NOTE: every comb output gets its hold value first, so no path leaves it unassigned (no latch).
   always_comb begin
      taps_d = taps_q;
      if (shift_en)
         taps_d = {taps_q[TAPS-2:0], din};
   end

   // NOTE: this array is flops, not RAM, and it is cleared on reset so a mid-sample reset leaves no history.
   // NOTE: sequential state uses <= so all taps update together from the pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         taps_q <= '0;
      else
         taps_q <= taps_d;
   end

   assign taps    = taps_q;
   assign rd_data = taps_q[rd_idx];

endmodule

// File: rtl/lms_error_calc.sv
// LMS upstream stage: delay line, 16-cycle shared-multiplier FIR, saturated error,
// and the one-cycle weight_cal_state strobe for the downstream weight update.
module lms_error_calc
   import lms_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic [XW-1:0] x_in,
   input  logic [EW-1:0] d_in,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WW-1:0] weight_in_0,  input  logic [WW-1:0] weight_in_1,
   input  logic [WW-1:0] weight_in_2,  input  logic [WW-1:0] weight_in_3,
   input  logic [WW-1:0] weight_in_4,  input  logic [WW-1:0] weight_in_5,
   input  logic [WW-1:0] weight_in_6,  input  logic [WW-1:0] weight_in_7,
   input  logic [WW-1:0] weight_in_8,  input  logic [WW-1:0] weight_in_9,
   input  logic [WW-1:0] weight_in_10, input  logic [WW-1:0] weight_in_11,
   input  logic [WW-1:0] weight_in_12, input  logic [WW-1:0] weight_in_13,
   input  logic [WW-1:0] weight_in_14, input  logic [WW-1:0] weight_in_15,
   output logic [XW-1:0] reff_0,  output logic [XW-1:0] reff_1,
   output logic [XW-1:0] reff_2,  output logic [XW-1:0] reff_3,
   output logic [XW-1:0] reff_4,  output logic [XW-1:0] reff_5,
   output logic [XW-1:0] reff_6,  output logic [XW-1:0] reff_7,
   output logic [XW-1:0] reff_8,  output logic [XW-1:0] reff_9,
   output logic [XW-1:0] reff_10, output logic [XW-1:0] reff_11,
   output logic [XW-1:0] reff_12, output logic [XW-1:0] reff_13,
   output logic [XW-1:0] reff_14, output logic [XW-1:0] reff_15,
   output logic [EW-1:0] e,
   output logic [EW-1:0] y_out,
   output logic          weight_cal_state
);

   state_t                  state_q, state_d;
   logic [KW-1:0]           k_q, k_d;
   logic signed [ACCW-1:0]  acc_q, acc_d;
   logic [EW-1:0]           d_q, d_d, e_q, e_d, y_q, y_d;

   logic                    accept;
   logic [TAPS-1:0][WW-1:0] weights;
   logic [TAPS-1:0][XW-1:0] taps;
   logic [XW-1:0]           rd_data;
   logic signed [WW-1:0]    w_k;
   logic signed [XW-1:0]    x_k;
   logic signed [XW+WW-1:0] prod;
   logic signed [ACCW-1:0]  prod_ext;
   logic [EW-1:0]           y_sat;
   logic signed [EW:0]      e_diff;

   assign weights = {weight_in_15, weight_in_14, weight_in_13, weight_in_12,
                     weight_in_11, weight_in_10, weight_in_9,  weight_in_8,
                     weight_in_7,  weight_in_6,  weight_in_5,  weight_in_4,
                     weight_in_3,  weight_in_2,  weight_in_1,  weight_in_0};

   assign accept = in_valid && (state_q == IDLE);

   lms_tap_line u_tap_line (
      .clk      (clk),
      .rstn     (rstn),
      .shift_en (accept),
      .din      (x_in),
      .rd_idx   (k_q),
      .taps     (taps),
      .rd_data  (rd_data)
   );

   assign {reff_15, reff_14, reff_13, reff_12, reff_11, reff_10, reff_9, reff_8,
           reff_7,  reff_6,  reff_5,  reff_4,  reff_3,  reff_2,  reff_1, reff_0} = taps;

   // Full 46-bit signed product, sign-extended into the 50-bit accumulator.
   assign w_k      = weights[k_q];
   assign x_k      = rd_data;
   assign prod     = $signed({{XW{w_k[WW-1]}}, w_k}) * $signed({{WW{x_k[XW-1]}}, x_k});
   assign prod_ext = {{(ACCW-XW-WW){prod[XW+WW-1]}}, prod};

   // Error uses the already-saturated y, computed one bit wider than EW.
   assign y_sat  = sat32(acc_q >>> Y_SHIFT);
   assign e_diff = $signed({d_q[EW-1], d_q}) - $signed({y_sat[EW-1], y_sat});

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      d_d     = d_q;
      e_d     = e_q;
      y_d     = y_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = MAC;
            k_d     = '0;
            acc_d   = '0;
            d_d     = d_in;
         end
         MAC: begin
            acc_d = acc_q + prod_ext;
            k_d   = k_q + 1'b1;
            if (k_q == KW'(TAPS-1))
               state_d = ERR;
         end
         ERR: begin
            y_d     = y_sat;
            e_d     = sat32({{(ACCW-EW-1){e_diff[EW]}}, e_diff});
            state_d = UPD;
         end
         UPD:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         d_q     <= '0;
         e_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         d_q     <= d_d;
         e_q     <= e_d;
         y_q     <= y_d;
      end
   end

   assign in_ready         = (state_q == IDLE);
   assign weight_cal_state = (state_q == UPD);
   assign e                = e_q;
   assign y_out            = y_q;

endmodule

// File: tb/tb_lms_error_calc.sv
// Directed self-checking bench for lms_error_calc: reset, timing, shift, arithmetic,
// saturation, back-to-back accepts and reset during MAC.
module tb_lms_error_calc;

   logic        clk = 1'b0;
   logic        rstn;
   logic [13:0] x_in;
   logic [31:0] d_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] w [16];
   logic [13:0] reff [16];
   logic [31:0] e;
   logic [31:0] y_out;
   logic        weight_cal_state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lms_error_calc dut (
      .clk(clk), .rstn(rstn), .x_in(x_in), .d_in(d_in),
      .in_valid(in_valid), .in_ready(in_ready),
      .weight_in_0(w[0]),   .weight_in_1(w[1]),   .weight_in_2(w[2]),   .weight_in_3(w[3]),
      .weight_in_4(w[4]),   .weight_in_5(w[5]),   .weight_in_6(w[6]),   .weight_in_7(w[7]),
      .weight_in_8(w[8]),   .weight_in_9(w[9]),   .weight_in_10(w[10]), .weight_in_11(w[11]),
      .weight_in_12(w[12]), .weight_in_13(w[13]), .weight_in_14(w[14]), .weight_in_15(w[15]),
      .reff_0(reff[0]),   .reff_1(reff[1]),   .reff_2(reff[2]),   .reff_3(reff[3]),
      .reff_4(reff[4]),   .reff_5(reff[5]),   .reff_6(reff[6]),   .reff_7(reff[7]),
      .reff_8(reff[8]),   .reff_9(reff[9]),   .reff_10(reff[10]), .reff_11(reff[11]),
      .reff_12(reff[12]), .reff_13(reff[13]), .reff_14(reff[14]), .reff_15(reff[15]),
      .e(e), .y_out(y_out), .weight_cal_state(weight_cal_state)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic set_weights(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] rest);
      w[0] = w0;
      w[1] = w1;
      for (int i = 2; i < 16; i++) w[i] = rest;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rstn     = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Waits (bounded) for in_ready, accepts one sample, then runs to cycle 19 of its window.
   task automatic run_sample(input logic [13:0] x, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      end
      x_in     = x;
      d_in     = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (19) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn     = 1'b0;
      x_in     = 14'($urandom);
      d_in     = $urandom;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      checks++;
      if (e !== 32'd0) begin errors++; $display("FAIL rst_e: got %h want 0", e); end
      checks++;
      if (y_out !== 32'd0) begin errors++; $display("FAIL rst_y: got %h want 0", y_out); end
      checks++;
      if (weight_cal_state !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", weight_cal_state); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (reff[i] !== 14'd0) begin errors++; $display("FAIL rst_reff%0d: got %h want 0", i, reff[i]); end
      end
      in_valid = 1'b0;
      rstn     = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || weight_cal_state !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle: in_ready=%b strobe=%b want 1/0", in_ready, weight_cal_state);
         end
      end
   endtask

   task automatic test_zero_weights();
      set_weights(32'd0, 32'd0, 32'd0);
      @(negedge clk);
      x_in     = 14'd100;
      d_in     = 32'd1000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         checks++;
         if (weight_cal_state !== (c == 18)) begin
            errors++;
            $display("FAIL strobe_c%0d: got %b want %b", c, weight_cal_state, (c == 18));
         end
         checks++;
         if (in_ready !== (c == 19)) begin
            errors++;
            $display("FAIL in_ready_c%0d: got %b want %b", c, in_ready, (c == 19));
         end
         if (c == 17) begin
            checks++;
            if (e !== 32'd0) begin errors++; $display("FAIL e_before_err: got %h want 0", e); end
         end
      end
      checks++;
      if (reff[0] !== 14'd100) begin errors++; $display("FAIL zero_reff0: got %0d want 100", reff[0]); end
      checks++;
      if (y_out !== 32'd0) begin errors++; $display("FAIL zero_y: got %h want 0", y_out); end
      checks++;
      if (e !== 32'd1000) begin errors++; $display("FAIL zero_e: got %0d want 1000", e); end
   endtask

   task automatic test_shift();
      logic [13:0] exp_t [16];
      do_reset();
      set_weights(32'd0, 32'd0, 32'd0);
      run_sample(14'd1, 32'd0);
      run_sample(14'd2, 32'd0);
      run_sample(14'd3, 32'd0);
      for (int i = 0; i < 16; i++) exp_t[i] = 14'd0;
      exp_t[0] = 14'd3;
      exp_t[1] = 14'd2;
      exp_t[2] = 14'd1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (reff[i] !== exp_t[i]) begin errors++; $display("FAIL shift_reff%0d: got %0d want %0d", i, reff[i], exp_t[i]); end
      end
   endtask

   // Taps {5, -3}, weights {1.0, -1.0} in Q16 -> y = 8.
   task automatic test_arith();
      logic [31:0] d_tab [3];
      logic [31:0] e_tab [3];
      d_tab[0] = 32'd10; e_tab[0] = 32'd2;
      d_tab[1] = 32'd8;  e_tab[1] = 32'd0;
      d_tab[2] = 32'd0;  e_tab[2] = 32'hFFFF_FFF8;
      for (int t = 0; t < 3; t++) begin
         do_reset();
         set_weights(32'h0001_0000, 32'hFFFF_0000, 32'd0);
         run_sample(14'h3FFD, 32'd0);
         run_sample(14'd5, d_tab[t]);
         checks++;
         if (y_out !== 32'd8) begin errors++; $display("FAIL arith_y_%0d: got %h want 8", t, y_out); end
         checks++;
         if (e !== e_tab[t]) begin errors++; $display("FAIL arith_e_%0d: got %h want %h", t, e, e_tab[t]); end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      set_weights(32'hFFFF_FFFF, 32'd0, 32'd0);
      run_sample(14'd1, 32'h7FFF_FFFF);
      checks++;
      if (y_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_pos_y: got %h want ffffffff", y_out); end
      checks++;
      if (e !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos_e: got %h want 7fffffff", e); end
      set_weights(32'h0001_0000, 32'd0, 32'd0);
      run_sample(14'd1, 32'h8000_0000);
      checks++;
      if (y_out !== 32'd1) begin errors++; $display("FAIL sat_neg_y: got %h want 1", y_out); end
      checks++;
      if (e !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg_e: got %h want 80000000", e); end
      // All taps -8192 times weights -2^31: acc = 2^48, y clamps high, e = -(2^31-1).
      do_reset();
      set_weights(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      for (int i = 0; i < 16; i++) run_sample(14'h2000, 32'd0);
      checks++;
      if (y_out !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_y_clamp: got %h want 7fffffff", y_out); end
      checks++;
      if (e !== 32'h8000_0001) begin errors++; $display("FAIL sat_y_err: got %h want 80000001", e); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_weights(32'd0, 32'd0, 32'd0);
      x_in     = 14'd9;
      d_in     = 32'd0;
      in_valid = 1'b1;
      for (int i = 0; i <= 57; i++) begin
         checks++;
         if (in_ready !== ((i % 19) == 0)) begin
            errors++;
            $display("FAIL b2b_edge%0d: in_ready=%b want %b", i, in_ready, ((i % 19) == 0));
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_mid_mac();
      do_reset();
      set_weights(32'h0001_0000, 32'd0, 32'd0);
      run_sample(14'd4, 32'd77);
      checks++;
      if (e !== 32'd73) begin errors++; $display("FAIL pre_rst_e: got %0d want 73", e); end
      @(negedge clk);
      x_in     = 14'd6;
      d_in     = 32'd1;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
      checks++;
      if (e !== 32'd0 || y_out !== 32'd0) begin errors++; $display("FAIL mid_rst_ey: e=%h y=%h want 0/0", e, y_out); end
      checks++;
      if (reff[0] !== 14'd0 || reff[1] !== 14'd0) begin
         errors++;
         $display("FAIL mid_rst_taps: reff0=%0d reff1=%0d want 0/0", reff[0], reff[1]);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (weight_cal_state !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_quiet_c%0d: strobe=%b in_ready=%b want 0/1", c, weight_cal_state, in_ready);
         end
      end
      run_sample(14'd7, 32'd50);
      checks++;
      if (reff[0] !== 14'd7 || reff[1] !== 14'd0) begin
         errors++;
         $display("FAIL post_rst_taps: reff0=%0d reff1=%0d want 7/0", reff[0], reff[1]);
      end
      checks++;
      if (y_out !== 32'd7) begin errors++; $display("FAIL post_rst_y: got %0d want 7", y_out); end
      checks++;
      if (e !== 32'd43) begin errors++; $display("FAIL post_rst_e: got %0d want 43", e); end
   endtask

   initial begin
      test_reset();
      test_zero_weights();
      test_shift();
      test_arith();
      test_saturation();
      test_back_to_back();
      test_reset_mid_mac();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
